// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pairs consecutive words from an async FIFO read port into
// double-width output beats with a valid/ready handshake. A held odd word is
// emitted as a partial beat on flushReq.
// Optional feature: define FIFO_PACKER_TIMEOUT_EN to add an idle-flush counter
// driven by timeoutCycles (0 disables it). Without the macro timeoutCycles is ignored.
module fifo_rd_packer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_W  = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   fifoDataOut,
  input  logic                    fifoDataOutValid,
  output logic                    fifoPop,
  input  logic                    flushReq,
  input  logic [TIMEOUT_W-1:0]    timeoutCycles,
  output logic [2*DATA_WIDTH-1:0] outData,
  output logic [1:0]              outKeep,
  output logic                    outValid,
  input  logic                    outReady,
  output logic                    packerIdle
);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } packState_t;

  packState_t            state;
  logic [DATA_WIDTH-1:0] lowReg;
  logic                  outFree;
  logic                  flushCond;

  // Output slot can take a new beat when empty or draining this cycle.
  assign outFree    = !outValid || outReady;
  // A word is taken whenever it can go somewhere: into lowReg, or into a free output slot.
  assign fifoPop    = !reset && fifoDataOutValid && ((state == EMPTY) || outFree);
  assign packerIdle = (state == EMPTY) && !outValid;

`ifdef FIFO_PACKER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] idleCount;

  assign flushCond = flushReq || ((timeoutCycles != '0) && (idleCount == timeoutCycles));

  // Idle counter: counts cycles a low word has waited for its partner, saturating.
  always_ff @(posedge clock) begin
    if (reset) begin
      idleCount <= '0;
    end else if (fifoPop || (state == EMPTY)) begin
      idleCount <= '0;
    end else if (idleCount != {TIMEOUT_W{1'b1}}) begin
      idleCount <= idleCount + TIMEOUT_W'(1);
    end
  end
`else
  logic unusedTimeout;

  assign flushCond     = flushReq;
  assign unusedTimeout = ^timeoutCycles;
`endif

  // Packing FSM with registered output beat; a word wins over a flush in HALF.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= EMPTY;
      lowReg   <= '0;
      outValid <= 1'b0;
      outData  <= '0;
      outKeep  <= 2'b00;
    end else begin
      if (outValid && outReady) begin
        outValid <= 1'b0;
      end
      case (state)
        EMPTY: begin
          if (fifoPop) begin
            lowReg <= fifoDataOut;
            state  <= HALF;
          end
        end
        HALF: begin
          if (fifoPop) begin
            outData  <= {fifoDataOut, lowReg};
            outKeep  <= 2'b11;
            outValid <= 1'b1;
            state    <= EMPTY;
          end else if (flushCond && outFree) begin
            outData  <= {DATA_WIDTH'(0), lowReg};
            outKeep  <= 2'b01;
            outValid <= 1'b1;
            state    <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed self-checking bench for fifo_rd_packer (default build, DATA_WIDTH=32).
module tb_fifo_rd_packer;

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] fifoDataOut;
  logic          fifoDataOutValid;
  logic          fifoPop;
  logic          flushReq;
  logic [TW-1:0] timeoutCycles;
  logic [2*DW-1:0] outData;
  logic [1:0]    outKeep;
  logic          outValid;
  logic          outReady;
  logic          packerIdle;

  int nAsserts = 0;
  int nFails   = 0;

  fifo_rd_packer #(.DATA_WIDTH(DW), .TIMEOUT_W(TW)) dut (
    .clock(clock),
    .reset(reset),
    .fifoDataOut(fifoDataOut),
    .fifoDataOutValid(fifoDataOutValid),
    .fifoPop(fifoPop),
    .flushReq(flushReq),
    .timeoutCycles(timeoutCycles),
    .outData(outData),
    .outKeep(outKeep),
    .outValid(outValid),
    .outReady(outReady),
    .packerIdle(packerIdle)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input logic [63:0] data, input logic [1:0] keep);
    check({tag, "_valid"}, 64'(outValid), 64'(1));
    check({tag, "_data"}, outData, data);
    check({tag, "_keep"}, 64'(outKeep), 64'(keep));
  endtask

  initial begin
    reset            = 1'b1;
    fifoDataOut      = 32'hDEAD_0000;
    fifoDataOutValid = 1'b1;
    flushReq         = 1'b0;
    timeoutCycles    = '0;
    outReady         = 1'b1;

    // Reset state; fifoPop must stay low while reset is high.
    step();
    step();
    check("rst_pop", 64'(fifoPop), 64'(0));
    check("rst_valid", 64'(outValid), 64'(0));
    check("rst_data", outData, 64'h0);
    check("rst_keep", 64'(outKeep), 64'(0));
    check("rst_idle", 64'(packerIdle), 64'(1));
    reset            = 1'b0;
    fifoDataOutValid = 1'b0;
    check("idle_nopop", 64'(fifoPop), 64'(0));

    // Two consecutive words -> one full beat {B,A}.
    fifoDataOutValid = 1'b1;
    fifoDataOut      = 32'hAAAA_0001;
    #1 check("ab_popA", 64'(fifoPop), 64'(1));
    step();
    check("ab_halfIdle", 64'(packerIdle), 64'(0));
    check("ab_noBeatYet", 64'(outValid), 64'(0));
    fifoDataOut = 32'hBBBB_0002;
    #1 check("ab_popB", 64'(fifoPop), 64'(1));
    step();
    fifoDataOutValid = 1'b0;
    checkBeat("ab_beat", 64'hBBBB_0002_AAAA_0001, 2'b11);
    step();
    check("ab_drained", 64'(outValid), 64'(0));
    check("ab_idle", 64'(packerIdle), 64'(1));

    // Single word then flushReq -> partial beat {0,A}.
    fifoDataOutValid = 1'b1;
    fifoDataOut      = 32'hC1C1_0003;
    step();
    fifoDataOutValid = 1'b0;
    flushReq         = 1'b1;
    step();
    flushReq = 1'b0;
    checkBeat("fl_beat", 64'h0000_0000_C1C1_0003, 2'b01);
    step();
    check("fl_idle", 64'(packerIdle), 64'(1));
    // Flush while EMPTY does nothing.
    flushReq = 1'b1;
    step();
    flushReq = 1'b0;
    check("fl_empty", 64'(outValid), 64'(0));

    // Stalled beat: HALF word is not popped until downstream is ready.
    outReady         = 1'b0;
    fifoDataOutValid = 1'b1;
    fifoDataOut      = 32'hEEEE_0004;
    step();
    fifoDataOut = 32'hFFFF_0005;
    step();
    checkBeat("st_beat", 64'hFFFF_0005_EEEE_0004, 2'b11);
    fifoDataOut = 32'h6666_0006;
    #1 check("st_popEmpty", 64'(fifoPop), 64'(1));
    step();
    fifoDataOut = 32'h7777_0007;
    #1 check("st_noPop", 64'(fifoPop), 64'(0));
    step();
    check("st_noPop2", 64'(fifoPop), 64'(0));
    checkBeat("st_hold", 64'hFFFF_0005_EEEE_0004, 2'b11);
    outReady = 1'b1;
    #1 check("st_popReady", 64'(fifoPop), 64'(1));
    step();
    fifoDataOutValid = 1'b0;
    checkBeat("st_next", 64'h7777_0007_6666_0006, 2'b11);
    step();
    check("st_drained", 64'(outValid), 64'(0));

    // Word and flush together in HALF -> full beat only.
    fifoDataOutValid = 1'b1;
    fifoDataOut      = 32'h1111_0008;
    step();
    fifoDataOut = 32'h2222_0009;
    flushReq    = 1'b1;
    step();
    fifoDataOutValid = 1'b0;
    flushReq         = 1'b0;
    checkBeat("wf_beat", 64'h2222_0009_1111_0008, 2'b11);
    step();
    check("wf_noPartial", 64'(outValid), 64'(0));
    check("wf_idle", 64'(packerIdle), 64'(1));

    // Back-to-back stream sustains one beat every two clocks.
    fifoDataOutValid = 1'b1;
    fifoDataOut      = 32'h3333_0001;
    step();
    fifoDataOut = 32'h3333_0002;
    step();
    checkBeat("bb_beat1", 64'h3333_0002_3333_0001, 2'b11);
    fifoDataOut = 32'h3333_0003;
    #1 check("bb_pop3", 64'(fifoPop), 64'(1));
    step();
    check("bb_gap", 64'(outValid), 64'(0));
    fifoDataOut = 32'h3333_0004;
    step();
    fifoDataOutValid = 1'b0;
    checkBeat("bb_beat2", 64'h3333_0004_3333_0003, 2'b11);
    step();

`ifndef FIFO_PACKER_TIMEOUT_EN
    // timeoutCycles is ignored in the default build: a lone word waits.
    timeoutCycles    = 8'd4;
    fifoDataOutValid = 1'b1;
    fifoDataOut      = 32'h4444_000A;
    step();
    fifoDataOutValid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("to_noBeat", 64'(outValid), 64'(0));
    check("to_held", 64'(packerIdle), 64'(0));
    flushReq = 1'b1;
    step();
    flushReq = 1'b0;
    checkBeat("to_flush", 64'h0000_0000_4444_000A, 2'b01);
    step();
    timeoutCycles = '0;
`endif

    // Reset with a held word and a stalled beat discards both.
    outReady         = 1'b0;
    fifoDataOutValid = 1'b1;
    fifoDataOut      = 32'h5555_000B;
    step();
    fifoDataOut = 32'h5555_000C;
    step();
    fifoDataOut = 32'h5555_000D;
    step();
    fifoDataOutValid = 1'b0;
    check("rm_stalled", 64'(outValid), 64'(1));
    reset = 1'b1;
    #1 check("rm_popInReset", 64'(fifoPop), 64'(0));
    step();
    reset = 1'b0;
    check("rm_valid", 64'(outValid), 64'(0));
    check("rm_idle", 64'(packerIdle), 64'(1));
    outReady         = 1'b1;
    fifoDataOutValid = 1'b1;
    fifoDataOut      = 32'h9999_000E;
    step();
    check("rm_noStale", 64'(outValid), 64'(0));
    fifoDataOut = 32'h9999_000F;
    step();
    fifoDataOutValid = 1'b0;
    checkBeat("rm_beat", 64'h9999_000F_9999_000E, 2'b11);
    step();
    check("rm_final_idle", 64'(packerIdle), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one FIFO word; output beat is 2*DATA_WIDTH.
REQ-002 SHALL have parameter TIMEOUT_W, default 8: width of timeout counter and timeoutCycles.
REQ-003 SHALL have port clock, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have port fifoDataOut, input, DATA_WIDTH: head word from the upstream async FIFO read side.
REQ-006 SHALL have port fifoDataOutValid, input, 1: head word is present.
REQ-007 SHALL have port fifoPop, output, 1: head word is consumed this cycle.
REQ-008 SHALL have port flushReq, input, 1: emit any held partial beat.
REQ-009 SHALL have port timeoutCycles, input, TIMEOUT_W: idle-flush threshold; 0 disables it.
REQ-010 SHALL have port outData, output, 2*DATA_WIDTH: packed beat; the first word is in the low half.
REQ-011 SHALL have port outKeep, output, 2: word-valid mask; 2'b11 marks a full beat, 2'b01 a partial beat.
REQ-012 SHALL have port outValid, output, 1, and port outReady, input, 1: downstream valid/ready handshake.
REQ-013 SHALL have port packerIdle, output, 1: no word is held and outValid is low.

Function
REQ-014 SHALL be in state EMPTY (no low word held) or state HALF (one low word held in lowReg).
REQ-015 SHALL define outFree = !outValid | outReady.
REQ-016 SHALL drive fifoPop combinationally as fifoDataOutValid & (state==EMPTY | outFree); fifoPop SHALL be 0 whenever fifoDataOutValid is 0.
REQ-017 In EMPTY, on fifoPop, SHALL load lowReg with fifoDataOut and move to HALF.
REQ-018 In HALF, on fifoPop, SHALL register outData={fifoDataOut,lowReg}, outKeep=2'b11 and outValid=1 on the next edge, then move to EMPTY; latency is 1 cycle.
REQ-019 In HALF with no pop, when a flush condition holds and outFree, SHALL register outData={0,lowReg}, outKeep=2'b01 and outValid=1, then move to EMPTY.
REQ-020 When an incoming word and a flush condition occur in the same cycle in HALF, the word SHALL take priority and produce a full beat; the flush is consumed.
REQ-021 A flush condition in EMPTY SHALL have no effect.
REQ-022 outValid, outData and outKeep SHALL hold stable while outValid & !outReady.
REQ-023 When outValid & outReady hold and no new beat is formed, outValid SHALL clear on the next edge.
REQ-024 A back-to-back drain with new beat formation in the same cycle SHALL sustain 1 beat per 2 clocks with no bubble beyond that.
REQ-025 Word order SHALL be preserved; no word SHALL be dropped or duplicated.

Reset
REQ-026 While reset=1 at an edge, the block SHALL set state=EMPTY, lowReg=0, outValid=0, outData=0, outKeep=0 and timeout counter=0.
REQ-027 During reset, fifoPop SHALL be 0.
REQ-028 packerIdle SHALL be 1 after reset.
REQ-029 Reset mid-operation SHALL discard both a held low word and a pending beat.

Configuration
REQ-030 With FIFO_PACKER_TIMEOUT_EN defined, the block SHALL contain a TIMEOUT_W counter: cleared on each fifoPop and in EMPTY, incremented (saturating) each cycle in HALF.
REQ-031 With FIFO_PACKER_TIMEOUT_EN defined, counter==timeoutCycles with timeoutCycles!=0 in HALF SHALL be a flush condition, in addition to flushReq.
REQ-032 Without FIFO_PACKER_TIMEOUT_EN, the counter SHALL be absent, timeoutCycles SHALL be ignored, and flushReq SHALL be the only flush condition.

Verification
REQ-033 Words A,B valid on consecutive cycles, outReady=1 -> one beat {B,A}, outKeep=11, outValid high 1 cycle after B popped.
REQ-034 Single word A, then flushReq=1 for 1 cycle -> beat {0,A}, outKeep=01; packerIdle=1 after handshake.
REQ-035 outReady=0 with beat pending, HALF, word C valid -> fifoPop=0 and beat stable until outReady=1; C popped in that same cycle.
REQ-036 HALF with flushReq and word D in the same cycle -> full beat {D,low}, keep=11, no partial beat.
REQ-037 FIFO_PACKER_TIMEOUT_EN defined, timeoutCycles=4, single word A -> partial beat {0,A} registered 4 cycles after the pop; with timeoutCycles=0 -> no beat.
REQ-038 Reset asserted in HALF with a beat stalled -> next cycle outValid=0, packerIdle=1; the next words A,B give a beat {B,A} with no stale data.
